// File: rtl/boid_frame_scheduler.sv
// Per-frame sequencer for the 1-bit boid display RAM: swap/clear, sweep every BPU
// through the read mux, write each boid pixel, and hold off CPU position writes meanwhile.
module boid_frame_scheduler #(
    parameter int MAX_BOIDS      = 4,
    parameter int BITS_FOR_BOIDS = (MAX_BOIDS > 1) ? $clog2(MAX_BOIDS) : 1,
    parameter int PIXEL_COUNT    = 307200,
    parameter int ADDR_WIDTH     = 19
) (
    input  logic                      clock,
    input  logic                      CPU_RESETN,
    input  logic                      screen_end,
    input  logic [ADDR_WIDTH-1:0]     boid_addr,
    input  logic                      cpu_boid_we,
    output logic [BITS_FOR_BOIDS-1:0] boid_sel,
    output logic                      ram_swap,
    output logic                      disp_we,
    output logic [ADDR_WIDTH-1:0]     disp_addr,
    output logic                      bpu_we_en,
    output logic                      cpu_stall,
    output logic                      busy,
    output logic                      frame_done,
    output logic [7:0]                overrun_cnt
);

    localparam logic [BITS_FOR_BOIDS-1:0] LAST_IDX  = BITS_FOR_BOIDS'(MAX_BOIDS - 1);
    localparam logic [ADDR_WIDTH:0]       PIX_LIMIT = (ADDR_WIDTH + 1)'(PIXEL_COUNT);

    typedef enum logic [2:0] {S_IDLE, S_SWAP, S_SEL, S_WRITE, S_DONE} state_t;

    state_t                      state_q, state_d;
    logic [BITS_FOR_BOIDS-1:0]   idx_q, idx_d;
    logic                        se_q;
    logic                        pending_q, pending_d;
    logic [7:0]                  overrun_q, overrun_d;
    logic [BITS_FOR_BOIDS-1:0]   sel_q, sel_d;
    logic                        swap_q, swap_d;
    logic                        we_q, we_d;
    logic [ADDR_WIDTH-1:0]       disp_addr_q, disp_addr_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        bpu_en_q, bpu_en_d;
    logic                        start;
    logic                        in_range;

    // A held screen_end level yields a single start event.
    assign start    = screen_end & ~se_q;
    // Extra MSB keeps the compare correct even if PIXEL_COUNT == 2**ADDR_WIDTH.
    assign in_range = ({1'b0, boid_addr} < PIX_LIMIT);

    always_ff @(posedge clock) begin
        if (!CPU_RESETN) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            se_q        <= 1'b0;
            pending_q   <= 1'b0;
            overrun_q   <= '0;
            sel_q       <= '0;
            swap_q      <= 1'b0;
            we_q        <= 1'b0;
            disp_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bpu_en_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            se_q        <= screen_end;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            sel_q       <= sel_d;
            swap_q      <= swap_d;
            we_q        <= we_d;
            disp_addr_q <= disp_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bpu_en_q    <= bpu_en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (start && (state_q != S_IDLE)) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else if (overrun_q != 8'hFF) begin
                overrun_d = overrun_q + 8'd1;
            end
        end
        case (state_q)
            S_IDLE:  if (start) state_d = S_SWAP;
            S_SWAP: begin
                idx_d   = '0;
                state_d = S_SEL;
            end
            S_SEL:   state_d = S_WRITE;
            S_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_SEL;
                end
            end
            S_DONE: begin
                // An edge arriving in DONE counts as pending and is consumed right here.
                state_d   = (pending_q || start) ? S_SWAP : S_IDLE;
                pending_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sel_d       = '0;
        swap_d      = 1'b0;
        we_d        = 1'b0;
        done_d      = 1'b0;
        busy_d      = (state_d != S_IDLE);
        bpu_en_d    = (state_d == S_IDLE);
        disp_addr_d = disp_addr_q;
        if (state_q == S_SEL) disp_addr_d = boid_addr;
        case (state_d)
            S_SWAP:  swap_d = 1'b1;
            S_SEL:   sel_d  = idx_d;
            S_WRITE: begin
                sel_d = idx_d;
                we_d  = in_range;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    assign boid_sel    = sel_q;
    assign ram_swap    = swap_q;
    assign disp_we     = we_q;
    assign disp_addr   = disp_addr_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign bpu_we_en   = bpu_en_q;
    assign overrun_cnt = overrun_q;
    assign cpu_stall   = cpu_boid_we & busy_q;

endmodule

// File: doc/boid_frame_scheduler.md
Name: boid_frame_scheduler

Overview:
- Sequences the per-frame rebuild of the 1-bit boid display RAM.
- On each VGA end-of-frame pulse it:
  - issues a one-cycle RAM swap/clear,
  - walks every BPU through the boid read mux,
  - writes each boid's pixel address into the display RAM.
- Also gates CPU position writes to the BPUs while a sweep is in progress, so a boid never moves mid-sweep.
- Sits between VGAController, the BPU array/read mux, RAM_resettable and the CPU register taps.

Parameters:
- MAX_BOIDS, 4, number of BPU instances swept per frame (>=1).
- BITS_FOR_BOIDS, $clog2(MAX_BOIDS) (min 1), width of the boid select index.
- PIXEL_COUNT, 307200, number of valid display addresses (640*480).
- ADDR_WIDTH, 19, display RAM address width.

Ports:
- clock, in, 1, system clock (50 MHz domain); all logic on posedge.
- CPU_RESETN, in, 1, synchronous active-low reset.
- screen_end, in, 1, end-of-frame level/pulse from VGAController; may stay high for several cycles.
- boid_addr, in, ADDR_WIDTH, pixel address of the currently selected boid (combinational from the read mux).
- cpu_boid_we, in, 1, CPU request to write a boid position (OR of the one-hot decoder outputs).
- boid_sel, out, BITS_FOR_BOIDS, read-mux select.
- ram_swap, out, 1, one-cycle pulse to RAM_resettable reset.
- disp_we, out, 1, display RAM write enable (write data is constant 1).
- disp_addr, out, ADDR_WIDTH, display RAM write address.
- bpu_we_en, out, 1, enable ANDed into every BPU write enable.
- cpu_stall, out, 1, cpu_boid_we & busy.
- busy, out, 1, sweep in progress.
- frame_done, out, 1, one-cycle pulse when a sweep completes.
- overrun_cnt, out, 8, saturating count of frame starts lost to back-to-back sweeps.

Behaviour:
- Reset (CPU_RESETN=0 at posedge): state IDLE.
  - boid_sel=0, disp_addr=0, overrun_cnt=0, pending=0, screen_end history reg=0.
  - ram_swap, disp_we, busy, frame_done all 0; bpu_we_en=1.
  - Reset mid-sweep aborts immediately; no further disp_we.
- Start event: rising edge of screen_end (registered prev value). A level held high counts once.
- Registered outputs: all outputs registered except cpu_stall.
- busy = (state != IDLE); bpu_we_en = ~busy.
- FSM states, one state per cycle unless stated:
  - IDLE: on start -> SWAP.
  - SWAP: ram_swap=1, boid_sel=0, idx=0 -> SEL.
  - SEL: boid_sel=idx; at end of cycle capture boid_addr into disp_addr -> WRITE.
  - WRITE:
    - disp_we = (captured addr < PIXEL_COUNT); out-of-range addresses are skipped silently.
    - If idx==MAX_BOIDS-1 -> DONE; else idx+1 -> SEL.
  - DONE: frame_done=1, boid_sel=0.
    - If pending: clear pending -> SWAP.
    - Else -> IDLE.
- Timing: start edge seen at cycle T.
  - ram_swap high in T+1.
  - First disp_we in T+3.
  - Boid k written in T+3+2k.
  - frame_done in T+2+2*MAX_BOIDS.
  - Sweep length 2*MAX_BOIDS+2 cycles.
- Overlap:
  - Start edge while busy with pending=0: set pending.
  - Start edge while pending=1 already: increment overrun_cnt, saturating at 255; the edge is dropped.
  - Start edge in DONE: treated as busy, so it sets pending and re-sweeps immediately.
- disp_we is never high in the same cycle as ram_swap.
- disp_addr holds its value when disp_we=0.
- CPU gating:
  - The CPU is not stalled by this block structurally; cpu_stall is informational and the wrapper holds the CPU write.
  - Any cpu_boid_we while busy is blocked by bpu_we_en=0.

Test Plan:
- Basic sweep:
  - Stimulus: reset 2 cycles, MAX_BOIDS=4, boid_addr per sel = {6410, 100, 307199, 0}, screen_end high 1 cycle at T.
  - Required: ram_swap at T+1; disp_we at T+3/5/7/9 with disp_addr 6410, 100, 307199, 0; frame_done at T+10; busy low at T+11.
- Held screen_end:
  - Stimulus: screen_end high for 20 cycles.
  - Required: exactly one sweep (4 disp_we pulses, one frame_done); overrun_cnt=0.
- Out of range:
  - Stimulus: boid 2 address = 307200 or 0x7FFFF.
  - Required: no disp_we in boid 2's WRITE cycle; the other three boids are written.
- Back-to-back:
  - Stimulus: edges at T, T+4, T+6.
  - Required: second sweep's ram_swap at T+11 (DONE->SWAP, no IDLE gap); overrun_cnt=1.
- CPU interlock:
  - Stimulus: cpu_boid_we=1 held from T to T+15.
  - Required: bpu_we_en=0 and cpu_stall=1 for T+1..T+10; bpu_we_en=1 and cpu_stall=0 from T+11.
- Reset mid-sweep:
  - Stimulus: CPU_RESETN=0 at T+5.
  - Required: at T+6 busy=0, disp_we=0, boid_sel=0, overrun_cnt=0; a next edge starts a clean sweep.
